// File: rtl/snake_step_engine.sv
`default_nettype none
// ============================================================================
// Module   : snake_step_engine
// Purpose  : Snake movement core. Advances the head one grid cell per step
//            tick, keeps the body as a shift-register history and detects
//            wall/self collision. Direction codes: TOP=00 DOWN=01 LEFT=10
//            RIGHT=11. Define WALL_WRAP_EN to wrap at the grid edges instead
//            of dying there.
// Revision : 1.0 - initial release
// ============================================================================
module snake_step_engine #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int INIT_X   = 16,
    parameter int INIT_Y   = 12,
    parameter int STEP_DIV = 5_000_000,
    localparam int X_W     = $clog2(GRID_W),
    localparam int Y_W     = $clog2(GRID_H),
    localparam int L_W     = $clog2(MAX_LEN + 1)
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    input  logic           start,
    input  logic [1:0]     direction,
    input  logic           grow,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic [X_W-1:0] tail_x,
    output logic [Y_W-1:0] tail_y,
    output logic           tail_vld,
    output logic           step_pulse,
    output logic [L_W-1:0] length,
    output logic           running,
    output logic           game_over
);

    localparam logic [1:0] C_DIR_TOP   = 2'b00;
    localparam logic [1:0] C_DIR_DOWN  = 2'b01;
    localparam logic [1:0] C_DIR_LEFT  = 2'b10;
    localparam int         IDX_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         CNT_W       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [L_W-1:0]   C_MAX_LEN  = L_W'(MAX_LEN);
    localparam logic [L_W-1:0]   C_INIT_LEN = L_W'(INIT_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    state_t           r_state;
    logic [X_W-1:0]   r_seg_x [MAX_LEN];
    logic [Y_W-1:0]   r_seg_y [MAX_LEN];
    logic [L_W-1:0]   r_len;
    logic [1:0]       r_last_dir;
    logic [CNT_W-1:0] r_cnt;
    logic             r_grow_pend;
    logic [X_W-1:0]   r_tail_x;
    logic [Y_W-1:0]   r_tail_y;
    logic             r_tail_vld;
    logic             r_step_pulse;
    logic             r_running;
    logic             r_game_over;

    logic [X_W-1:0]   w_init_x [MAX_LEN];
    logic [Y_W-1:0]   w_init_y [MAX_LEN];
    logic             w_tick;
    logic             w_growing;
    logic [1:0]       w_nd;
    logic [X_W-1:0]   w_nx;
    logic [Y_W-1:0]   w_ny;
    logic             w_wall;
    logic             w_self;
    logic             w_dead;
    logic [L_W-1:0]   w_cmp_len;
    logic [IDX_W-1:0] w_tail_idx;

    // Initial body: vertical line hanging below the head.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_init
            assign w_init_x[gi] = X_W'(INIT_X);
            assign w_init_y[gi] = (gi < INIT_LEN) ? Y_W'(INIT_Y + gi) : Y_W'(INIT_Y);
        end
    endgenerate

    assign w_tick     = (r_state == S_RUN) && (r_cnt == C_CNT_LAST);
    assign w_growing  = (r_grow_pend | grow) && (r_len < C_MAX_LEN);
    // Opposite codes differ only in bit 0, so a reversal keeps the old heading.
    assign w_nd       = ((direction[1] == r_last_dir[1]) && (direction[0] != r_last_dir[0]))
                        ? r_last_dir : direction;
    assign w_tail_idx = IDX_W'(r_len - L_W'(1));
    // The tail cell is vacated this step unless the snake is growing.
    assign w_cmp_len  = w_growing ? r_len : (r_len - L_W'(1));
    assign w_dead     = w_wall | w_self;

    always_comb begin
        w_nx   = r_seg_x[0];
        w_ny   = r_seg_y[0];
        w_wall = 1'b0;
        case (w_nd)
            C_DIR_TOP: begin
                if (r_seg_y[0] == '0) begin
`ifdef WALL_WRAP_EN
                    w_ny = Y_W'(GRID_H - 1);
`else
                    w_wall = 1'b1;
`endif
                end else begin
                    w_ny = r_seg_y[0] - Y_W'(1);
                end
            end
            C_DIR_DOWN: begin
                if (r_seg_y[0] == Y_W'(GRID_H - 1)) begin
`ifdef WALL_WRAP_EN
                    w_ny = '0;
`else
                    w_wall = 1'b1;
`endif
                end else begin
                    w_ny = r_seg_y[0] + Y_W'(1);
                end
            end
            C_DIR_LEFT: begin
                if (r_seg_x[0] == '0) begin
`ifdef WALL_WRAP_EN
                    w_nx = X_W'(GRID_W - 1);
`else
                    w_wall = 1'b1;
`endif
                end else begin
                    w_nx = r_seg_x[0] - X_W'(1);
                end
            end
            default: begin
                if (r_seg_x[0] == X_W'(GRID_W - 1)) begin
`ifdef WALL_WRAP_EN
                    w_nx = '0;
`else
                    w_wall = 1'b1;
`endif
                end else begin
                    w_nx = r_seg_x[0] + X_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        w_self = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((L_W'(i) < w_cmp_len) && (r_seg_x[i] == w_nx) && (r_seg_y[i] == w_ny)) begin
                w_self = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= w_init_x[i];
                r_seg_y[i] <= w_init_y[i];
            end
            r_len        <= C_INIT_LEN;
            r_last_dir   <= C_DIR_TOP;
            r_cnt        <= '0;
            r_grow_pend  <= 1'b0;
            r_tail_x     <= '0;
            r_tail_y     <= '0;
            r_tail_vld   <= 1'b0;
            r_step_pulse <= 1'b0;
            r_running    <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_step_pulse <= 1'b0;
            r_tail_vld   <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (w_tick) begin
                        r_cnt       <= '0;
                        r_grow_pend <= 1'b0;
                        r_last_dir  <= w_nd;
                        if (w_dead) begin
                            r_state     <= S_DEAD;
                            r_running   <= 1'b0;
                            r_game_over <= 1'b1;
                        end else begin
                            for (int i = MAX_LEN - 1; i > 0; i--) begin
                                r_seg_x[i] <= r_seg_x[i-1];
                                r_seg_y[i] <= r_seg_y[i-1];
                            end
                            r_seg_x[0]   <= w_nx;
                            r_seg_y[0]   <= w_ny;
                            r_step_pulse <= 1'b1;
                            if (w_growing) begin
                                r_len <= r_len + L_W'(1);
                            end else begin
                                r_tail_x   <= r_seg_x[w_tail_idx];
                                r_tail_y   <= r_seg_y[w_tail_idx];
                                r_tail_vld <= 1'b1;
                            end
                        end
                    end else begin
                        r_cnt       <= r_cnt + CNT_W'(1);
                        r_grow_pend <= r_grow_pend | grow;
                    end
                end
                S_DEAD: begin
                    r_cnt       <= '0;
                    r_grow_pend <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            r_seg_x[i] <= w_init_x[i];
                            r_seg_y[i] <= w_init_y[i];
                        end
                        r_len       <= C_INIT_LEN;
                        r_last_dir  <= C_DIR_TOP;
                        r_tail_x    <= '0;
                        r_tail_y    <= '0;
                        r_state     <= S_RUN;
                        r_running   <= 1'b1;
                        r_game_over <= 1'b0;
                    end
                end
                default: begin
                    r_cnt       <= '0;
                    r_grow_pend <= 1'b0;
                    if (start) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign head_x     = r_seg_x[0];
    assign head_y     = r_seg_y[0];
    assign tail_x     = r_tail_x;
    assign tail_y     = r_tail_y;
    assign tail_vld   = r_tail_vld;
    assign step_pulse = r_step_pulse;
    assign length     = r_len;
    assign running    = r_running;
    assign game_over  = r_game_over;

endmodule
`default_nettype wire
